// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher with branch redirect.
// One read is in flight at a time; a fetched word is held for decode until
// it is accepted, then the next sequential word is requested.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        misalign_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_inst_pc;
    logic              r_misalign;
    logic [XLEN-1:0]   w_redirect_word;

    // Redirect targets are forced to word alignment.
    assign w_redirect_word = {redirect_pc[XLEN-1:2], 2'b00};

    // Request and delivery strobes are pure decodes of the state register.
    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = (r_state == S_HOLD);
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign misalign_err   = r_misalign;

    // Fetch FSM: reset beats redirect, redirect beats every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_inst     <= '0;
            r_inst_pc  <= '0;
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_word;
            if (redirect_pc[1:0] != 2'b00) begin
                r_misalign <= 1'b1;
            end
            case (r_state)
                // An accepted old-path request still owes a response.
                S_REQ:   r_state <= imem_req_ready ? S_DRAIN : S_REQ;
                // Same-cycle response is dropped; otherwise drain it later.
                S_WAIT:  r_state <= imem_resp_valid ? S_REQ : S_DRAIN;
                // Keep draining until the owed response shows up.
                S_DRAIN: r_state <= imem_resp_valid ? S_REQ : S_DRAIN;
                // Any same-cycle handshake is a transfer; pc follows redirect.
                S_HOLD:  r_state <= S_REQ;
                default: r_state <= S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_inst    <= imem_resp_data;
                        r_inst_pc <= r_pc;
                        r_state   <= S_HOLD;
                    end
                end
                S_DRAIN: begin
                    if (imem_resp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        r_pc    <= r_pc + XLEN'(4);
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        misalign_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .misalign_err   (misalign_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from REQ: accept, 1-cycle response, hold for stall cycles, accept.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int stall);
        chk("req_valid", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_req_addr, a);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        chk("wait_inst_valid", 32'(inst_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = d;
        tick();
        imem_resp_valid = 1'b0;
        for (int i = 0; i < stall; i++) begin
            chk("stall_inst_valid", 32'(inst_valid), 32'd1);
            chk("stall_inst", inst, d);
            chk("stall_inst_pc", inst_pc, a);
            chk("stall_no_req", 32'(imem_req_valid), 32'd0);
            tick();
        end
        chk("hold_inst_valid", 32'(inst_valid), 32'd1);
        chk("hold_inst", inst, d);
        chk("hold_inst_pc", inst_pc, a);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        inst_ready      = 1'b0;
        tick();
        tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        rst = 1'b0;

        // Sequential stream, then a 5-cycle decode stall on the third word.
        fetch(32'h0000_0000, 32'h1111_0000, 0);
        fetch(32'h0000_0004, 32'h1111_0004, 0);
        fetch(32'h0000_0008, 32'h1111_0008, 5);

        // Redirect in WAIT; owed response arrives two cycles later and is drained.
        chk("pre_drain_addr", imem_req_addr, 32'h0000_000C);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        chk("drain_req_valid", 32'(imem_req_valid), 32'd0);
        chk("drain_inst_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("drain2_req_valid", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        imem_resp_valid = 1'b0;
        chk("drain_stale_kept_out", inst, 32'h1111_0008);
        fetch(32'h0000_0100, 32'h2222_0100, 0);

        // Redirect coincident with the response in WAIT: data dropped.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h0000_0200;
        tick();
        imem_resp_valid = 1'b0;
        redirect_valid  = 1'b0;
        chk("wr_inst_valid", 32'(inst_valid), 32'd0);
        chk("wr_inst_kept", inst, 32'h2222_0100);
        fetch(32'h0000_0200, 32'h3333_0200, 0);

        // Misaligned redirect in REQ without ready: aligned address next cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0106;
        tick();
        redirect_valid = 1'b0;
        chk("mis_flag", 32'(misalign_err), 32'd1);
        fetch(32'h0000_0104, 32'h4444_0104, 0);
        chk("mis_sticky", 32'(misalign_err), 32'd1);

        // Redirect in HOLD with same-cycle handshake: pc takes the redirect.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h5555_0108;
        tick();
        imem_resp_valid = 1'b0;
        chk("hr_inst_pc", inst_pc, 32'h0000_0108);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("hr_inst_valid", 32'(inst_valid), 32'd0);

        // Top-of-memory word wraps to zero.
        fetch(32'hFFFF_FFFC, 32'h6666_FFFC, 0);
        chk("wrap_addr", imem_req_addr, 32'h0000_0000);
        fetch(32'h0000_0000, 32'h7777_0000, 0);

        // Reset while a request is outstanding.
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("wrst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("wrst_req_addr", imem_req_addr, 32'h0000_0000);
        chk("wrst_inst_valid", 32'(inst_valid), 32'd0);
        chk("wrst_inst", inst, 32'h0);
        chk("wrst_misalign", 32'(misalign_err), 32'd0);

        // Stray response in REQ is ignored.
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hABCD_0000;
        tick();
        imem_resp_valid = 1'b0;
        chk("stray_req_valid", 32'(imem_req_valid), 32'd1);
        chk("stray_inst", inst, 32'h0);

        // Redirect in REQ with ready: accepted old request is drained.
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("rr_req_valid", 32'(imem_req_valid), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_0000;
        tick();
        imem_resp_valid = 1'b0;
        chk("rr_inst", inst, 32'h0);
        fetch(32'h0000_0300, 32'h8888_0300, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
